// File: rtl/data_bus_timer_pkg.sv
// Shared register-map constants and bus types for the data-bus timer.
package data_bus_timer_pkg;

  localparam int REG_BUS_W = 32;
  typedef logic [REG_BUS_W-1:0] reg_bus_t;

  typedef enum logic [1:0] {
    TMR_COUNT   = 2'd0,
    TMR_COMPARE = 2'd1,
    TMR_CTRL    = 2'd2,
    TMR_STATUS  = 2'd3
  } tmr_reg_e;

  localparam int CTRL_EN     = 0;
  localparam int CTRL_AUTO   = 1;
  localparam int CTRL_IE     = 2;
  localparam int STATUS_PEND = 0;

  localparam reg_bus_t CTRL_MASK = 32'h0000_0007;
  // The register window is 16 bytes, so only addr[31:4] takes part in decode.
  localparam reg_bus_t WIN_MASK  = 32'hFFFF_FFF0;

endpackage

// File: rtl/data_bus_timer_bus_byte_merge.sv
// Combinational byte-lane merge: lane k takes new data when sel_i[k] is set.
module data_bus_timer_bus_byte_merge
  import data_bus_timer_pkg::*;
(
  input  logic [REG_BUS_W-1:0]   old_i,
  input  logic [REG_BUS_W-1:0]   new_i,
  input  logic [REG_BUS_W/8-1:0] sel_i,
  output logic [REG_BUS_W-1:0]   merged_o
);

  always_comb begin
    merged_o = old_i;
    for (int k = 0; k < REG_BUS_W/8; k++) begin
      if (sel_i[k]) merged_o[8*k +: 8] = new_i[8*k +: 8];
    end
  end

endmodule

// File: rtl/data_bus_timer.sv
// Zero-wait-state memory-mapped timer: prescaled 32-bit counter, compare, match flag and level IRQ.
module data_bus_timer
  import data_bus_timer_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h1000_0000,
  parameter int unsigned PRESCALE  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ce,
  input  logic                 we,
  input  logic [31:0]          addr,
  input  logic [3:0]           sel,
  input  logic [REG_BUS_W-1:0] data_i,
  output logic [REG_BUS_W-1:0] data_o,
  output logic                 timer_int_o
);

  localparam logic [15:0] PS_LAST = 16'(PRESCALE - 1);

  logic     hit;
  logic     wr_en;
  tmr_reg_e reg_sel;

  logic [15:0] prescaler_q, prescaler_d;
  reg_bus_t    count_q, count_d;
  reg_bus_t    compare_q, compare_d;
  reg_bus_t    ctrl_q, ctrl_d;
  logic        pend_q, pend_d;
  logic        timer_int_q;

  logic     tick;
  logic     match;
  logic     pend_clr;
  reg_bus_t count_tick;
  reg_bus_t count_merged;
  reg_bus_t compare_merged;
  reg_bus_t ctrl_merged;

  assign hit     = ce & ~rst & ((addr & WIN_MASK) == (BASE_ADDR & WIN_MASK));
  assign wr_en   = hit & we;
  assign reg_sel = tmr_reg_e'(addr[3:2]);

  assign tick  = ctrl_q[CTRL_EN] & (prescaler_q == PS_LAST);
  assign match = tick & (count_q == compare_q);

  always_comb begin
    count_tick = count_q;
    if (tick) begin
      if (match && ctrl_q[CTRL_AUTO]) count_tick = '0;
      else                            count_tick = count_q + 32'd1;
    end
  end

  // COUNT merges over the tick result so unwritten lanes still advance.
  data_bus_timer_bus_byte_merge u_merge_count (
    .old_i    (count_tick),
    .new_i    (data_i),
    .sel_i    (sel),
    .merged_o (count_merged)
  );

  data_bus_timer_bus_byte_merge u_merge_compare (
    .old_i    (compare_q),
    .new_i    (data_i),
    .sel_i    (sel),
    .merged_o (compare_merged)
  );

  data_bus_timer_bus_byte_merge u_merge_ctrl (
    .old_i    (ctrl_q),
    .new_i    (data_i),
    .sel_i    (sel),
    .merged_o (ctrl_merged)
  );

  always_comb begin
    count_d   = count_tick;
    compare_d = compare_q;
    ctrl_d    = ctrl_q;
    pend_clr  = 1'b0;
    if (wr_en) begin
      case (reg_sel)
        TMR_COUNT:   count_d   = count_merged;
        TMR_COMPARE: compare_d = compare_merged;
        TMR_CTRL:    ctrl_d    = ctrl_merged & CTRL_MASK;
        TMR_STATUS:  pend_clr  = sel[0] & data_i[STATUS_PEND];
      endcase
    end
    // A new match beats a simultaneous write-1-to-clear.
    pend_d = match | (pend_q & ~pend_clr);
    if (!ctrl_q[CTRL_EN] || !ctrl_d[CTRL_EN] || tick) prescaler_d = '0;
    else                                              prescaler_d = prescaler_q + 16'd1;
  end

  always_comb begin
    data_o = '0;
    if (hit && !we) begin
      case (reg_sel)
        TMR_COUNT:   data_o = count_q;
        TMR_COMPARE: data_o = compare_q;
        TMR_CTRL:    data_o = ctrl_q;
        TMR_STATUS:  data_o = {{(REG_BUS_W-1){1'b0}}, pend_q};
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prescaler_q <= '0;
      count_q     <= '0;
      compare_q   <= 32'hFFFF_FFFF;
      ctrl_q      <= '0;
      pend_q      <= 1'b0;
      timer_int_q <= 1'b0;
    end else begin
      prescaler_q <= prescaler_d;
      count_q     <= count_d;
      compare_q   <= compare_d;
      ctrl_q      <= ctrl_d;
      pend_q      <= pend_d;
      timer_int_q <= pend_q & ctrl_q[CTRL_IE];
    end
  end

  assign timer_int_o = timer_int_q;

endmodule

// File: tb/tb_data_bus_timer.sv
// Directed bench for data_bus_timer: one instance with PRESCALE=1, one with PRESCALE=4.
module tb_data_bus_timer;

  localparam logic [31:0] BASE = 32'h1000_0000;
  localparam logic [31:0] A_COUNT   = BASE + 32'h0;
  localparam logic [31:0] A_COMPARE = BASE + 32'h4;
  localparam logic [31:0] A_CTRL    = BASE + 32'h8;
  localparam logic [31:0] A_STATUS  = BASE + 32'hC;

  logic        clk = 1'b0;
  logic        rst;
  logic        ce1, ce4, we;
  logic [31:0] addr, data_wr;
  logic [3:0]  sel;
  logic [31:0] d1, d4;
  logic        int1, int4;

  logic [31:0] exp_q[$];
  int vectors = 0;
  int miscompares = 0;

  always #10 clk = ~clk;

  data_bus_timer #(.BASE_ADDR(BASE), .PRESCALE(1)) u_dut1 (
    .clk(clk), .rst(rst), .ce(ce1), .we(we), .addr(addr), .sel(sel),
    .data_i(data_wr), .data_o(d1), .timer_int_o(int1)
  );

  data_bus_timer #(.BASE_ADDR(BASE), .PRESCALE(4)) u_dut4 (
    .clk(clk), .rst(rst), .ce(ce4), .we(we), .addr(addr), .sel(sel),
    .data_i(data_wr), .data_o(d4), .timer_int_o(int4)
  );

  task automatic compare_out(input logic [31:0] obs, input string tag);
    logic [31:0] exp;
    exp = exp_q.pop_front();
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic bus_rd(input int dut, input bit wait_edge, input logic [31:0] a,
                        input logic [31:0] exp, input string tag);
    if (wait_edge) @(negedge clk);
    exp_q.push_back(exp);
    ce1 = (dut == 1); ce4 = (dut == 4); we = 1'b0; addr = a;
    #1;
    compare_out((dut == 4) ? d4 : d1, tag);
    ce1 = 1'b0; ce4 = 1'b0;
  endtask

  task automatic int_chk(input int dut, input bit wait_edge, input logic exp, input string tag);
    if (wait_edge) @(negedge clk);
    exp_q.push_back({31'b0, exp});
    #1;
    compare_out({31'b0, (dut == 4) ? int4 : int1}, tag);
  endtask

  // Drives from the current (pre-posedge) point; commits on the next posedge.
  task automatic bus_wr(input int dut, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    ce1 = (dut == 1); ce4 = (dut == 4); we = 1'b1; addr = a; data_wr = d; sel = s;
    @(negedge clk);
    ce1 = 1'b0; ce4 = 1'b0; we = 1'b0;
  endtask

  initial begin
    rst = 1'b1; ce1 = 1'b0; ce4 = 1'b0; we = 1'b0;
    addr = A_COMPARE; data_wr = '0; sel = '0;
    #2;
    ce1 = 1'b1;
    exp_q.push_back(32'h0);
    #1 compare_out(d1, "rd_in_reset");
    ce1 = 1'b0;
    int_chk(1, 0, 1'b0, "int_in_reset");
    @(negedge clk);
    rst = 1'b0;
    bus_rd(1, 0, A_COUNT,   32'h0,         "rst_count");
    bus_rd(1, 0, A_COMPARE, 32'hFFFF_FFFF, "rst_compare");
    bus_rd(1, 0, A_CTRL,    32'h0,         "rst_ctrl");
    bus_rd(1, 0, A_STATUS,  32'h0,         "rst_status");

    // Byte-lane writes and ignored write with ce low
    bus_wr(1, A_COMPARE, 32'h0, 4'b1111);
    bus_wr(1, A_COMPARE, 32'hAABB_CCDD, 4'b0100);
    bus_rd(1, 0, A_COMPARE, 32'h00BB_0000, "lane_merge");
    bus_wr(0, A_COMPARE, 32'hFFFF_FFFF, 4'b1111);
    bus_rd(1, 0, A_COMPARE, 32'h00BB_0000, "ce_low_write");

    // Prescaled counting (PRESCALE=4)
    bus_wr(4, A_CTRL, 32'h1, 4'b1111);
    repeat (19) @(posedge clk);
    bus_rd(4, 1, A_COUNT, 32'd4, "cnt_19clk");
    bus_rd(4, 1, A_COUNT, 32'd5, "cnt_20clk");
    bus_wr(4, A_CTRL, 32'h0, 4'b1111);

    // Match with AUTO and IE (PRESCALE=1)
    bus_wr(1, A_COMPARE, 32'd3, 4'b1111);
    bus_wr(1, A_CTRL, 32'h7, 4'b1111);
    repeat (3) @(posedge clk);
    bus_rd(1, 1, A_COUNT,  32'd3, "m_count3");
    bus_rd(1, 0, A_STATUS, 32'd0, "m_pend0");
    int_chk(1, 0, 1'b0, "m_int0");
    bus_rd(1, 1, A_COUNT,  32'd0, "m_auto_clr");
    bus_rd(1, 0, A_STATUS, 32'd1, "m_pend1");
    int_chk(1, 0, 1'b0, "m_int_not_yet");
    int_chk(1, 1, 1'b1, "m_int_rise");
    bus_wr(1, A_CTRL, 32'h6, 4'b1111);
    bus_rd(1, 1, A_COUNT,  32'd2, "en_clr_tick");
    bus_rd(1, 0, A_STATUS, 32'd1, "pend_held");
    int_chk(1, 0, 1'b1, "int_held");
    bus_wr(1, A_STATUS, 32'h1, 4'b0001);
    bus_rd(1, 0, A_STATUS, 32'd0, "w1c");
    int_chk(1, 1, 1'b0, "int_drop");

    // W1C on the same edge as a match
    bus_wr(1, A_CTRL, 32'h7, 4'b1111);
    @(negedge clk);
    bus_wr(1, A_STATUS, 32'h1, 4'b0001);
    bus_rd(1, 0, A_STATUS, 32'd1, "w1c_vs_match");
    bus_rd(1, 0, A_COUNT,  32'd0, "match_auto2");
    bus_wr(1, A_CTRL, 32'h6, 4'b1111);

    // CPU write to COUNT on a tick edge, full and partial lanes
    bus_wr(1, A_CTRL, 32'h7, 4'b1111);
    bus_wr(1, A_COUNT, 32'h100, 4'b1111);
    bus_rd(1, 0, A_COUNT, 32'h100, "wr_vs_tick");
    bus_wr(1, A_COUNT, 32'h55, 4'b0001);
    bus_rd(1, 0, A_COUNT, 32'h155, "lane_vs_tick");
    bus_wr(1, A_CTRL, 32'h6, 4'b1111);
    bus_rd(1, 1, A_COUNT, 32'h156, "en_clr_tick2");
    bus_wr(1, A_STATUS, 32'h1, 4'b1110);
    bus_rd(1, 0, A_STATUS, 32'd1, "w1c_sel0_low");
    bus_wr(1, A_STATUS, 32'h1, 4'b0001);
    bus_rd(1, 0, A_STATUS, 32'd0, "w1c_again");

    // 32-bit wrap without a match
    bus_wr(1, A_COMPARE, 32'd5, 4'b1111);
    bus_wr(1, A_COUNT, 32'hFFFF_FFFE, 4'b1111);
    bus_wr(1, A_CTRL, 32'h1, 4'b1111);
    bus_rd(1, 1, A_COUNT,  32'hFFFF_FFFF, "wrap_max");
    bus_rd(1, 1, A_COUNT,  32'h0,         "wrap_zero");
    bus_rd(1, 0, A_STATUS, 32'd0,         "wrap_no_pend");
    bus_wr(1, A_CTRL, 32'h6, 4'b1111);

    // Address decode
    bus_rd(1, 0, BASE + 32'h9,  32'h6, "addr_lsb_ignored");
    bus_rd(1, 0, BASE + 32'h10, 32'h0, "out_of_window");
    bus_rd(0, 0, A_CTRL,        32'h0, "ce_low_read");

    // Asynchronous reset mid-operation with the interrupt asserted
    bus_wr(1, A_COMPARE, 32'd1, 4'b1111);
    bus_wr(1, A_CTRL, 32'h7, 4'b1111);
    @(negedge clk);
    int_chk(1, 1, 1'b1, "pre_rst_int");
    exp_q.push_back(32'd1);
    ce1 = 1'b1; we = 1'b0; addr = A_COMPARE;
    #1 compare_out(d1, "pre_rst_rd");
    rst = 1'b1;
    exp_q.push_back(32'h0);
    #1 compare_out(d1, "rst_async_data");
    int_chk(1, 0, 1'b0, "rst_async_int");
    ce1 = 1'b0;
    bus_wr(1, A_CTRL, 32'h7, 4'b1111);
    rst = 1'b0;
    bus_rd(1, 0, A_CTRL,    32'h0,         "rst2_ctrl");
    bus_rd(1, 0, A_COMPARE, 32'hFFFF_FFFF, "rst2_compare");
    bus_rd(1, 0, A_COUNT,   32'h0,         "rst2_count");
    bus_rd(1, 0, A_STATUS,  32'h0,         "rst2_status");
    int_chk(1, 1, 1'b0, "rst2_int");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
